// File: rtl/harness_pkg.sv
// Shared definitions for the processor/regfile harness.
// Holds the dump sequencer state encoding and default register-file geometry.
package harness_pkg;

    localparam int unsigned NumRegsDef = 32;
    localparam int unsigned IdxWDef    = $clog2(NumRegsDef);

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StRun,
        StSettle,
        StOut,
        StDone
    } state_e;

endpackage

// File: rtl/cycle_counter.sv
// Run-cycle counter for the dump sequencer.
// Ports:
//   clock, reset  - clock and asynchronous active-low reset
//   clear         - synchronous clear (wins over enable)
//   enable        - count up one per edge
//   limit         - run budget; tc flags count == limit-1
//   count         - current count (registered)
//   tc            - terminal-count flag (combinational from count/limit)
module cycle_counter #(
    parameter int unsigned CYC_W = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CYC_W-1:0] limit,
    output logic [CYC_W-1:0] count,
    output logic             tc
);

    logic [CYC_W-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CYC_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    // limit==0 never reaches RUN, so the wrapped compare value is harmless.
    assign tc    = (count_q == (limit - CYC_W'(1)));

endmodule

// File: rtl/reg_dump_ctrl.sv
// Run-and-dump sequencer: on start, pulses processor reset, runs the processor for a
// latched cycle budget, then hijacks regfile read port A and streams every register
// (index, value) out over a valid/ready interface.
// Ports:
//   clock, reset           - clock and asynchronous active-low reset
//   start, abort           - begin a run (IDLE/DONE only) / return to IDLE
//   num_cycles             - run budget, latched on accepted start
//   cpu_reset, cpu_run     - processor reset and clock-enable
//   cycle_count            - cycles elapsed in RUN
//   test_mode, test_reg    - read-port-A hijack select and index
//   reg_data               - regfile port A read data (combinational)
//   dump_valid/ready/idx/data - dump stream
//   busy, done             - status
module reg_dump_ctrl
    import harness_pkg::*;
#(
    parameter int unsigned NUM_REGS = NumRegsDef,
    parameter int unsigned IDX_W    = IdxWDef,
    parameter int unsigned CYC_W    = 10,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [CYC_W-1:0]  num_cycles,
    output logic              cpu_reset,
    output logic              cpu_run,
    output logic [CYC_W-1:0]  cycle_count,
    output logic              test_mode,
    output logic [IDX_W-1:0]  test_reg,
    input  logic [DATA_W-1:0] reg_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [IDX_W-1:0]  dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              busy,
    output logic              done
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_REGS - 1);

    state_e              state_d, state_q;
    logic [CYC_W-1:0]    budget_d, budget_q;
    logic [IDX_W-1:0]    idx_d, idx_q;
    logic [IDX_W-1:0]    dump_idx_d, dump_idx_q;
    logic [DATA_W-1:0]   dump_data_d, dump_data_q;
    logic                cpu_reset_d, cpu_reset_q;
    logic                cpu_run_d, cpu_run_q;
    logic                test_mode_d, test_mode_q;
    logic [IDX_W-1:0]    test_reg_d, test_reg_q;
    logic                dump_valid_d, dump_valid_q;
    logic                busy_d, busy_q;
    logic                done_d, done_q;
    logic                cnt_clear, cnt_en, cnt_tc;

    cycle_counter #(
        .CYC_W (CYC_W)
    ) u_cycle_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .limit  (budget_q),
        .count  (cycle_count),
        .tc     (cnt_tc)
    );

    always_comb begin
        state_d     = state_q;
        budget_d    = budget_q;
        idx_d       = idx_q;
        dump_idx_d  = dump_idx_q;
        dump_data_d = dump_data_q;
        cnt_clear   = 1'b0;

        if (abort) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_d   = StClr;
                        budget_d  = num_cycles;
                        idx_d     = '0;
                        cnt_clear = 1'b1;
                    end
                end
                StClr:    state_d = (budget_q == '0) ? StSettle : StRun;
                StRun:    if (cnt_tc) state_d = StSettle;
                StSettle: begin
                    state_d     = StOut;
                    dump_idx_d  = idx_q;
                    dump_data_d = reg_data;
                end
                StOut: begin
                    // dump_valid is high throughout OUT, so ready alone completes the beat.
                    if (dump_ready) begin
                        if (idx_q == LastIdx) begin
                            state_d = StDone;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = StSettle;
                        end
                    end
                end
                default:  state_d = StIdle;
            endcase
        end

        if (state_d == StIdle) begin
            budget_d    = '0;
            idx_d       = '0;
            dump_idx_d  = '0;
            dump_data_d = '0;
            cnt_clear   = 1'b1;
        end

        cnt_en = (state_q == StRun) && !abort;

        // Outputs decoded from the next state so every output comes straight from a flop.
        cpu_reset_d  = (state_d == StClr);
        cpu_run_d    = (state_d == StRun);
        test_mode_d  = (state_d == StSettle) || (state_d == StOut);
        test_reg_d   = test_mode_d ? idx_d : '0;
        dump_valid_d = (state_d == StOut);
        busy_d       = cpu_reset_d || cpu_run_d || test_mode_d;
        done_d       = (state_d == StDone);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            budget_q     <= '0;
            idx_q        <= '0;
            dump_idx_q   <= '0;
            dump_data_q  <= '0;
            cpu_reset_q  <= 1'b0;
            cpu_run_q    <= 1'b0;
            test_mode_q  <= 1'b0;
            test_reg_q   <= '0;
            dump_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            budget_q     <= budget_d;
            idx_q        <= idx_d;
            dump_idx_q   <= dump_idx_d;
            dump_data_q  <= dump_data_d;
            cpu_reset_q  <= cpu_reset_d;
            cpu_run_q    <= cpu_run_d;
            test_mode_q  <= test_mode_d;
            test_reg_q   <= test_reg_d;
            dump_valid_q <= dump_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign cpu_reset  = cpu_reset_q;
    assign cpu_run    = cpu_run_q;
    assign test_mode  = test_mode_q;
    assign test_reg   = test_reg_q;
    assign dump_valid = dump_valid_q;
    assign dump_idx   = dump_idx_q;
    assign dump_data  = dump_data_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Directed bench for reg_dump_ctrl with a behavioural regfile (r_i = 3*i + off).
module tb_reg_dump_ctrl;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned IDX_W    = 5;
    localparam int unsigned CYC_W    = 10;
    localparam int unsigned DATA_W   = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [CYC_W-1:0]  num_cycles = '0;
    logic              cpu_reset, cpu_run, test_mode, dump_valid, busy, done;
    logic [CYC_W-1:0]  cycle_count;
    logic [IDX_W-1:0]  test_reg, dump_idx;
    logic [DATA_W-1:0] reg_data, dump_data;
    logic              dump_ready = 1'b1;
    logic [31:0]       off = '0;
    logic [57:0]       all_outs;

    int n_cmp = 0;
    int n_bad = 0;

    // Results of the most recent run_to_done call.
    int r_rst, r_run, r_beats, r_first, r_seq, r_stall, r_ovl, r_maxcc, r_done_cyc;
    bit r_done;

    reg_dump_ctrl #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .CYC_W    (CYC_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .num_cycles  (num_cycles),
        .cpu_reset   (cpu_reset),
        .cpu_run     (cpu_run),
        .cycle_count (cycle_count),
        .test_mode   (test_mode),
        .test_reg    (test_reg),
        .reg_data    (reg_data),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .dump_idx    (dump_idx),
        .dump_data   (dump_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    always_comb reg_data = test_mode ? (DATA_W'(test_reg) * 32'd3 + off) : 32'hdead_beef;

    assign all_outs = {cpu_reset, cpu_run, cycle_count, test_mode, test_reg, dump_valid,
                       dump_idx, dump_data, busy, done};

    function automatic logic [31:0] exp_data(input int i);
        return 32'(i * 3) + off;
    endfunction

    // Starts a run and observes it until done (or max_cyc negedges), gathering counts.
    task automatic run_to_done(input int nc, input bit rnd, input int max_cyc);
        int cyc;
        bit stalled;
        logic [IDX_W-1:0]  last_idx;
        logic [DATA_W-1:0] last_data;
        r_rst = 0; r_run = 0; r_beats = 0; r_first = -1; r_seq = 0; r_stall = 0;
        r_ovl = 0; r_maxcc = 0;
        stalled = 1'b0; last_idx = '0; last_data = '0;
        num_cycles = CYC_W'(nc);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        while (cyc <= max_cyc && !done) begin
            if (cpu_reset) r_rst++;
            if (cpu_run) r_run++;
            if (test_mode && (cpu_run || cpu_reset)) r_ovl++;
            if (int'(cycle_count) > r_maxcc) r_maxcc = int'(cycle_count);
            if (dump_valid) begin
                if (r_first < 0) r_first = cyc;
                if (dump_idx !== IDX_W'(r_beats) || dump_data !== exp_data(r_beats)) r_seq++;
                if (stalled && (dump_idx !== last_idx || dump_data !== last_data)) r_stall++;
                last_idx  = dump_idx;
                last_data = dump_data;
            end
            if (rnd) dump_ready = 1'($urandom_range(0, 1));
            stalled = dump_valid && !dump_ready;
            if (dump_valid && dump_ready) r_beats++;
            @(negedge clock);
            cyc++;
        end
        r_done_cyc = cyc;
        r_done     = done;
        dump_ready = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        n_cmp++;
        if (all_outs !== '0) begin
            n_bad++; $display("FAIL reset_low: got %h want 0", all_outs);
        end
        reset = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (all_outs !== '0) begin
            n_bad++; $display("FAIL reset_idle: got %h want 0", all_outs);
        end
    endtask

    task automatic test_basic();
        off = 32'd5;
        run_to_done(5, 1'b0, 200);
        n_cmp += 9;
        if (r_done !== 1'b1)  begin n_bad++; $display("FAIL basic_done: got %0d want 1", r_done); end
        if (r_rst != 1)       begin n_bad++; $display("FAIL basic_rst: got %0d want 1", r_rst); end
        if (r_run != 5)       begin n_bad++; $display("FAIL basic_run: got %0d want 5", r_run); end
        if (r_beats != 32)    begin n_bad++; $display("FAIL basic_beats: got %0d want 32", r_beats); end
        if (r_first != 8)     begin n_bad++; $display("FAIL basic_first: got %0d want 8", r_first); end
        if (r_seq != 0)       begin n_bad++; $display("FAIL basic_seq: got %0d want 0", r_seq); end
        if (r_ovl != 0)       begin n_bad++; $display("FAIL basic_ovl: got %0d want 0", r_ovl); end
        if (r_done_cyc != 71) begin n_bad++; $display("FAIL basic_donecyc: got %0d want 71", r_done_cyc); end
        if (cycle_count !== CYC_W'(5) || busy !== 1'b0 || test_mode !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_donestate: got cc=%0d busy=%0d tm=%0d want 5 0 0",
                     cycle_count, busy, test_mode);
        end
    endtask

    task automatic test_stall();
        off = 32'd0;
        run_to_done(2, 1'b1, 2000);
        n_cmp += 5;
        if (r_done !== 1'b1) begin n_bad++; $display("FAIL stall_done: got %0d want 1", r_done); end
        if (r_beats != 32)   begin n_bad++; $display("FAIL stall_beats: got %0d want 32", r_beats); end
        if (r_seq != 0)      begin n_bad++; $display("FAIL stall_seq: got %0d want 0", r_seq); end
        if (r_stall != 0)    begin n_bad++; $display("FAIL stall_hold: got %0d want 0", r_stall); end
        if (r_run != 2)      begin n_bad++; $display("FAIL stall_run: got %0d want 2", r_run); end
    endtask

    task automatic test_zero_budget();
        off = 32'd9;
        run_to_done(0, 1'b0, 200);
        n_cmp += 6;
        if (r_run != 0)       begin n_bad++; $display("FAIL zero_run: got %0d want 0", r_run); end
        if (r_maxcc != 0)     begin n_bad++; $display("FAIL zero_cc: got %0d want 0", r_maxcc); end
        if (r_rst != 1)       begin n_bad++; $display("FAIL zero_rst: got %0d want 1", r_rst); end
        if (r_first != 3)     begin n_bad++; $display("FAIL zero_first: got %0d want 3", r_first); end
        if (r_beats != 32 || r_seq != 0) begin
            n_bad++; $display("FAIL zero_beats: got %0d/%0d want 32/0", r_beats, r_seq);
        end
        if (r_done_cyc != 66) begin n_bad++; $display("FAIL zero_donecyc: got %0d want 66", r_done_cyc); end
    endtask

    task automatic test_abort();
        int k;
        off = 32'd11;
        num_cycles = CYC_W'(10);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        k = 0;
        while (!(cpu_run && cycle_count == CYC_W'(3)) && k < 40) begin
            @(negedge clock); k++;
        end
        n_cmp++;
        if (k >= 40) begin n_bad++; $display("FAIL abort_run_reach: got timeout want cc=3"); end
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        n_cmp++;
        if (cpu_run !== 1'b0 || busy !== 1'b0 || cycle_count !== '0 || test_mode !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_run: got run=%0d busy=%0d cc=%0d tm=%0d want 0 0 0 0",
                     cpu_run, busy, cycle_count, test_mode);
        end
        // Abort while a beat is pending and unaccepted.
        dump_ready = 1'b0;
        num_cycles = CYC_W'(2);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        k = 0;
        while (!dump_valid && k < 40) begin
            @(negedge clock); k++;
        end
        n_cmp++;
        if (dump_valid !== 1'b1 || dump_idx !== '0 || dump_data !== exp_data(0)) begin
            n_bad++;
            $display("FAIL abort_out_beat: got v=%0d idx=%0d data=%0d want 1 0 %0d",
                     dump_valid, dump_idx, dump_data, exp_data(0));
        end
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        n_cmp++;
        if (dump_valid !== 1'b0 || test_mode !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_out: got v=%0d tm=%0d busy=%0d want 0 0 0",
                     dump_valid, test_mode, busy);
        end
        dump_ready = 1'b1;
        run_to_done(1, 1'b0, 200);
        n_cmp += 2;
        if (r_first != 4) begin n_bad++; $display("FAIL abort_rerun_first: got %0d want 4", r_first); end
        if (r_beats != 32 || r_seq != 0 || r_done !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_rerun: got beats=%0d seq=%0d done=%0d want 32 0 1",
                     r_beats, r_seq, r_done);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        off = 32'd2;
        num_cycles = CYC_W'(3);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        k = 0;
        while (!(dump_valid && dump_idx == IDX_W'(12)) && k < 200) begin
            @(negedge clock); k++;
        end
        dump_ready = 1'b0;
        n_cmp++;
        if (dump_data !== exp_data(12)) begin
            n_bad++; $display("FAIL mid_beat12: got %0d want %0d", dump_data, exp_data(12));
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (all_outs !== '0) begin
            n_bad++; $display("FAIL mid_async: got %h want 0", all_outs);
        end
        @(negedge clock);
        reset = 1'b1;
        dump_ready = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (all_outs !== '0) begin
            n_bad++; $display("FAIL mid_release: got %h want 0", all_outs);
        end
        run_to_done(4, 1'b0, 200);
        n_cmp += 2;
        if (r_first != 7) begin n_bad++; $display("FAIL mid_fresh_first: got %0d want 7", r_first); end
        if (r_beats != 32 || r_seq != 0 || r_done !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_fresh: got beats=%0d seq=%0d done=%0d want 32 0 1",
                     r_beats, r_seq, r_done);
        end
    endtask

    task automatic test_restart();
        int k, runs, rsts;
        off = 32'd4;
        num_cycles = CYC_W'(6);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        runs = 0; rsts = 1; k = 0;
        while (!test_mode && k < 40) begin
            if (cpu_run) runs++;
            // Stray start with a different budget mid-RUN must be ignored.
            start = cpu_run && cycle_count == CYC_W'(2);
            num_cycles = start ? CYC_W'(2) : CYC_W'(6);
            @(negedge clock);
            if (cpu_reset) rsts++;
            k++;
        end
        start = 1'b0;
        n_cmp += 2;
        if (runs != 6) begin n_bad++; $display("FAIL ign_run: got %0d want 6", runs); end
        if (rsts != 1) begin n_bad++; $display("FAIL ign_rst: got %0d want 1", rsts); end
        k = 0;
        while (!done && k < 200) begin
            @(negedge clock); k++;
        end
        n_cmp++;
        if (done !== 1'b1) begin n_bad++; $display("FAIL ign_done: got %0d want 1", done); end
        run_to_done(7, 1'b0, 200);
        n_cmp += 3;
        if (r_run != 7) begin n_bad++; $display("FAIL restart_run: got %0d want 7", r_run); end
        if (r_rst != 1) begin n_bad++; $display("FAIL restart_rst: got %0d want 1", r_rst); end
        if (r_beats != 32 || r_seq != 0 || r_done !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_dump: got beats=%0d seq=%0d done=%0d want 32 0 1",
                     r_beats, r_seq, r_done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero_budget();
        test_abort();
        test_reset_mid();
        test_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_dump_ctrl.md
# reg_dump_ctrl

Run-and-dump sequencer for the processor/regfile harness. On `start` it pulses the processor reset, enables the processor for a programmed number of cycles, then takes over regfile read port A. It reads registers 0..NUM_REGS-1 in turn and streams each (index, value) pair out over a valid/ready interface for checking or logging.

## Interface
- NUM_REGS, 32, registers dumped (indices 0..NUM_REGS-1)
- IDX_W, 5, index width, clog2(NUM_REGS)
- CYC_W, 10, cycle-budget width
- DATA_W, 32, register data width
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- start  in  1  begin a run; sampled only in IDLE or DONE
- abort  in  1  return to IDLE from any state next edge
- num_cycles  in  CYC_W  run budget; latched on accepted `start`
- cpu_reset  out  1  active-high reset to processor/regfile
- cpu_run  out  1  processor clock-enable
- cycle_count  out  CYC_W  cycles elapsed in RUN
- test_mode  out  1  select for regfile read-port-A hijack mux
- test_reg  out  IDX_W  register index driven onto hijacked port A
- reg_data  in  DATA_W  regfile data_readRegA (combinational read)
- dump_valid  out  1  dump beat valid
- dump_ready  in  1  consumer accepts beat
- dump_idx  out  IDX_W  register index of beat
- dump_data  out  DATA_W  register value of beat
- busy  out  1  high in CLR, RUN, SETTLE, OUT
- done  out  1  high in DONE

## Operation
- States: IDLE, CLR, RUN, SETTLE, OUT, DONE.
- IDLE: all outputs 0. `start` -> CLR; latch num_cycles into budget, clear cycle_count and idx.
- CLR: cpu_reset=1 for exactly one cycle. -> RUN, or -> SETTLE if budget==0.
- RUN: cpu_run=1; cycle_count increments each edge. When cycle_count==budget-1 at the edge -> SETTLE. RUN therefore lasts exactly `budget` cycles. cycle_count then holds `budget`.
- SETTLE: cpu_run=0, test_mode=1, test_reg=idx. Lasts one cycle; at its closing edge reg_data is registered into dump_data and dump_idx<=idx. -> OUT.
- OUT: test_mode=1, dump_valid=1. dump_idx/dump_data stay stable until `dump_valid && dump_ready`. On handshake: if idx==NUM_REGS-1 -> DONE, else idx<=idx+1 -> SETTLE.
- DONE: done=1, test_mode=0, cpu_run=0; cycle_count held. `start` -> CLR (new run, num_cycles re-latched).
- `start` outside IDLE/DONE is ignored.
- `abort` (priority over all transitions except reset): -> IDLE next edge. dump_valid drops without handshake; this is the only case valid falls unaccepted.
- Register 0 is dumped like any other; its value comes from the regfile.

## Timing
- Reset values: state IDLE, every output 0, budget/idx/cycle_count 0.
- start->cpu_reset: 1 cycle. start->first dump_valid: budget+3 cycles (CLR, RUN×budget, SETTLE), assuming no abort.
- Each beat costs SETTLE+OUT: minimum 2 cycles per register with dump_ready held high. Full dump with ready tied high is 2·NUM_REGS cycles; then done asserts on the edge of the last handshake.
- test_mode asserts the cycle after the last RUN cycle. It is never high together with cpu_run or cpu_reset.
- All outputs are registered; no combinational path from dump_ready to dump_valid.
- Reset asserted mid-run: immediate return to IDLE with outputs 0. No partial beat is later emitted.

## Structure
- Shared package `harness_pkg`: state enum (IDLE, CLR, RUN, SETTLE, OUT, DONE), NUM_REGS/IDX_W defaults.
- Single module; the cycle counter may be a sub-module `cycle_counter` (load, enable, terminal-count flag).

## Test plan
- num_cycles=5, ready tied 1 -> cpu_reset high 1 cycle, cpu_run high exactly 5 cycles, 32 beats idx 0..31 on consecutive alternate cycles, done after 64 cycles of dumping.
- Regfile preloaded r_i=i*3, ready toggling 1/0 pseudo-randomly -> every beat dump_data=3*idx, idx/data stable while stalled, no beat lost or duplicated.
- num_cycles=0 -> CLR then straight to SETTLE; cycle_count stays 0; 32 beats delivered.
- abort asserted in RUN at cycle 3, and separately in OUT with ready low -> IDLE next edge, dump_valid=0, test_mode=0; later start runs cleanly from idx 0.
- reset driven low during OUT idx=12 -> all outputs 0 asynchronously; after release, start gives full fresh dump.
- start pulsed during RUN ignored; start in DONE with num_cycles=7 -> new run with cpu_run high 7 cycles.
